// File: rtl/alu_seq_multiplier_if.sv
// Handshake and data bundle between the control unit / register file and the
// sequential Booth multiplier.
interface alu_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       data1;
    logic [WIDTH-1:0]       data2;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       result;
    logic                   ovf;

    modport master (
        output start, data1, data2,
        input  busy, done, product, result, ovf
    );

    modport slave (
        input  start, data1, data2,
        output busy, done, product, result, ovf
    );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Multi-cycle signed radix-2 Booth multiplier, one step per clock; the low
// product byte feeds the ALU result mux and is held until the next completion.
module alu_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    alu_seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_next;

    logic [WIDTH:0]     acc_reg;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               qm1_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic               ovf_reg;
    logic               done_reg;

    logic [WIDTH:0]     step_sum;
    logic [WIDTH:0]     shift_acc;
    logic [WIDTH-1:0]   shift_q;
    logic               last_step;
    logic [2*WIDTH-1:0] final_product;
    logic [WIDTH:0]     product_upper;
    logic               final_ovf;

    // One Booth step: add/subtract M, then arithmetic shift of {A,Q,Q_-1}.
    // A is one bit wider than the operands so -128*-128 cannot overflow it.
    always_comb begin
        step_sum = acc_reg;
        case ({q_reg[0], qm1_reg})
            2'b01:   step_sum = acc_reg + m_reg;
            2'b10:   step_sum = acc_reg - m_reg;
            default: step_sum = acc_reg;
        endcase
        shift_acc     = {step_sum[WIDTH], step_sum[WIDTH:1]};
        shift_q       = {step_sum[0], q_reg[WIDTH-1:1]};
        last_step     = (count_reg == CW'(WIDTH - 1));
        final_product = {shift_acc[WIDTH-1:0], shift_q};
        product_upper = final_product[2*WIDTH-1:WIDTH-1];
        final_ovf     = (|product_upper) && !(&product_upper);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state == RUN);
        bus.done    = done_reg;
        bus.product = product_reg;
        bus.result  = product_reg[WIDTH-1:0];
        bus.ovf     = ovf_reg;
    end

    // Operands are latched only on acceptance in IDLE, so START or operand
    // changes during RUN are ignored; the result registers move only at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg     <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            count_reg   <= '0;
            product_reg <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_reg   <= '0;
                        m_reg     <= {bus.data1[WIDTH-1], bus.data1};
                        q_reg     <= bus.data2;
                        qm1_reg   <= 1'b0;
                        count_reg <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= shift_acc;
                    q_reg     <= shift_q;
                    qm1_reg   <= q_reg[0];
                    count_reg <= count_reg + CW'(1);
                    if (last_step) begin
                        product_reg <= final_product;
                        ovf_reg     <= final_ovf;
                        done_reg    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for the sequential Booth multiplier: reset, latency, signed
// corners, ignored START, abort by reset and back-to-back operation.
module tb_alu_seq_multiplier;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_seq_multiplier_if #(.WIDTH(8)) bus ();

    alu_seq_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive START for exactly one capture edge; returns one step after t0.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.data1 = a;
        bus.data2 = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && edges < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.product, bus.result, bus.ovf} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL reset_state busy=%b done=%b product=%h result=%h ovf=%b required all zero",
                     bus.busy, bus.done, bus.product, bus.result, bus.ovf);
        end
    endtask

    task automatic test_basic();
        int edges, busy_cnt, bad;
        start_op(8'd12, 8'd2);
        wait_done(edges, busy_cnt);
        checks++;
        if (edges !== 8 || bus.done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_latency edges=%0d done=%b required 8 and 1", edges, bus.done);
        end
        checks++;
        if (busy_cnt !== 8 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy cycles=%0d busy_at_done=%b required 8 and 0", busy_cnt, bus.busy);
        end
        checks++;
        if (bus.product !== 16'h0018 || bus.result !== 8'd24 || bus.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_value product=%h result=%h ovf=%b required 0018 18 0",
                     bus.product, bus.result, bus.ovf);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 16'h0018 || bus.result !== 8'd24)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL basic_hold bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        logic        vo [3];
        int edges, busy_cnt;
        va = '{8'hFB, 8'h80, 8'd20};
        vb = '{8'd3,  8'h80, 8'd10};
        vp = '{16'hFFF1, 16'h4000, 16'h00C8};
        vo = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            wait_done(edges, busy_cnt);
            checks++;
            if (bus.done !== 1'b1 || bus.product !== vp[i] || bus.result !== vp[i][7:0] || bus.ovf !== vo[i]) begin
                failures++;
                $display("[TB] FAIL signed_%0d done=%b product=%h result=%h ovf=%b required 1 %h %h %b",
                         i, bus.done, bus.product, bus.result, bus.ovf, vp[i], vp[i][7:0], vo[i]);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int edges, busy_cnt, extra;
        start_op(8'd12, 8'd2);
        tick();
        tick();
        bus.start = 1'b1;
        bus.data1 = 8'd5;
        bus.data2 = 8'd5;
        tick();
        bus.start = 1'b0;
        bus.data1 = 8'd9;
        bus.data2 = 8'd9;
        wait_done(edges, busy_cnt);
        checks++;
        if (bus.done !== 1'b1 || bus.product !== 16'h0018 || edges !== 5) begin
            failures++;
            $display("[TB] FAIL ignore_start done=%b product=%h edges=%0d required 1 0018 5",
                     bus.done, bus.product, edges);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.busy === 1'b1 || bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("[TB] FAIL ignore_no_second active_cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int edges, busy_cnt, dones;
        start_op(8'd7, 8'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.product, bus.result, bus.ovf} !== 27'h0) begin
            failures++;
            $display("[TB] FAIL abort_state busy=%b done=%b product=%h result=%h ovf=%b required all zero",
                     bus.busy, bus.done, bus.product, bus.result, bus.ovf);
        end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("[TB] FAIL abort_no_done active_cycles=%0d required 0", dones);
        end
        start_op(8'd7, 8'd7);
        wait_done(edges, busy_cnt);
        checks++;
        if (bus.done !== 1'b1 || bus.product !== 16'h0031 || bus.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_fresh done=%b product=%h ovf=%b required 1 0031 0",
                     bus.done, bus.product, bus.ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int edges, busy_cnt, gap, unstable, overlap;
        bus.start = 1'b1;
        bus.data1 = 8'd3;
        bus.data2 = 8'd4;
        tick();
        bus.data1 = 8'd6;
        bus.data2 = 8'hFE;
        wait_done(edges, busy_cnt);
        checks++;
        if (bus.done !== 1'b1 || bus.product !== 16'h000C || bus.result !== 8'h0C) begin
            failures++;
            $display("[TB] FAIL b2b_first done=%b product=%h result=%h required 1 000c 0c",
                     bus.done, bus.product, bus.result);
        end
        gap      = 0;
        unstable = 0;
        overlap  = 0;
        do begin
            tick();
            gap++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
            if (bus.done !== 1'b1 && bus.result !== 8'h0C) unstable++;
        end while (bus.done !== 1'b1 && gap < 20);
        bus.start = 1'b0;
        checks++;
        if (gap !== 9) begin
            failures++;
            $display("[TB] FAIL b2b_gap cycles=%0d required 9", gap);
        end
        checks++;
        if (bus.product !== 16'hFFF4 || bus.result !== 8'hF4 || bus.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_second product=%h result=%h ovf=%b required fff4 f4 0",
                     bus.product, bus.result, bus.ovf);
        end
        checks++;
        if (unstable !== 0 || overlap !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_hold unstable=%0d overlap=%0d required 0 0", unstable, overlap);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.data1 = 8'h00;
        bus.data2 = 8'h00;
        #2;
        test_reset();
        test_basic();
        test_signed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
